// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared types and helpers for the pipelined add/subtract unit.
//   op_e            - operation select encoding (OP_ADD / OP_SUB)
//   add_sub_flags_t - result flag bundle {cout, ovf, zero, neg}
//   sat_value()     - signed saturation constant for a given sign and width
package add_sub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } add_sub_flags_t;

    // Widest result the saturation helper can produce; callers truncate.
    localparam int unsigned SAT_MAX_W = 64;

    // sign=0 -> signed maximum 0111..1, sign=1 -> signed minimum 1000..0,
    // right-aligned in a SAT_MAX_W vector with zeros above bit width-1.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign,
                                                       input int unsigned width);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
            if (i + 1 < width)       v[i] = ~sign;
            else if (i + 1 == width) v[i] = sign;
        end
        return v;
    endfunction

endpackage

// File: rtl/add_sub_seg.sv
// add_sub_seg: one SEG_W-bit slice of the carry chain with registered sum
// and carry-out. The registers advance only when en is high.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   en         - pipeline advance
//   a, b_eff   - operand slices (b_eff already inverted for subtraction)
//   cin        - carry into this slice
//   sum, cout  - registered slice sum and carry-out
module add_sub_seg
    import add_sub_pkg::*;
#(
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b_eff,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    logic [SEG_W:0] total;

    assign total = {1'b0, a} + {1'b0, b_eff} + {{SEG_W{1'b0}}, cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            sum  <= total[SEG_W-1:0];
            cout <= total[SEG_W];
        end
    end

endmodule

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined WIDTH-bit add/subtract with valid/ready handshake.
// The carry chain is cut into NSEG = WIDTH/SEG_W slices, one per stage;
// latency is NSEG cycles counting the accept cycle, throughput one beat/cycle.
// Optional macro ADD_SUB_PIPE_SAT_EN adds sat_i for signed saturation.
// Ports:
//   clk_i, rst_i               - clock, synchronous active-high reset
//   in_valid_i, in_ready_o     - operand handshake (in_ready_o is combinational)
//   a_i, b_i, sub_i            - operands and op (0: A+B, 1: A-B)
//   sat_i                      - (ADD_SUB_PIPE_SAT_EN only) clamp on overflow
//   out_valid_o, out_ready_i   - result handshake
//   result_o                   - sum/difference modulo 2^WIDTH (or clamped)
//   cout_o, ovf_o, zero_o, neg_o - carry/borrow, signed overflow, zero, sign
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
`ifdef ADD_SUB_PIPE_SAT_EN
    input  logic             sat_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int unsigned NSEG = WIDTH / SEG_W;
    localparam int unsigned LAST = NSEG - 1;

    if (WIDTH % SEG_W != 0) begin : g_bad_width
        $error("add_sub_pipe: WIDTH must be a multiple of SEG_W");
    end

    // Global stall: everything shifts together or everything holds.
    logic adv;
    assign adv        = out_ready_i || !out_valid_o;
    assign in_ready_o = adv;

    logic sat_in;
`ifdef ADD_SUB_PIPE_SAT_EN
    assign sat_in = sat_i;
`else
    assign sat_in = 1'b0;
`endif

    logic [WIDTH-1:0] b_eff;
    assign b_eff = sub_i ? ~b_i : b_i;

    // *_q: stage output registers. stg_*: values loaded into them.
    // a_q/b_q carry the operands forward so later stages see their slices;
    // lo_q holds the already-finished lower result slices.
    logic [NSEG-1:0]            vld_pipe, sub_pipe, sat_pipe, carry;
    logic [NSEG-1:0]            stg_vld, stg_sub, stg_sat;
    logic [NSEG-1:0][WIDTH-1:0] a_q, b_q, lo_q;
    logic [NSEG-1:0][WIDTH-1:0] stg_a, stg_b, stg_lo, res_view;
    logic [NSEG-1:0][SEG_W-1:0] seg_sum;

    always_comb begin
        // res_view[k]: result bits settled at the output of stage k
        for (int k = 0; k < NSEG; k++) begin
            res_view[k]                  = lo_q[k];
            res_view[k][k*SEG_W +: SEG_W] = seg_sum[k];
        end
        stg_vld = '0;
        stg_sub = '0;
        stg_sat = '0;
        stg_a   = '0;
        stg_b   = '0;
        stg_lo  = '0;
        stg_vld[0] = in_valid_i;
        stg_sub[0] = sub_i;
        stg_sat[0] = sat_in;
        stg_a[0]   = a_i;
        stg_b[0]   = b_eff;
        for (int k = 1; k < NSEG; k++) begin
            stg_vld[k] = vld_pipe[k-1];
            stg_sub[k] = sub_pipe[k-1];
            stg_sat[k] = sat_pipe[k-1];
            stg_a[k]   = a_q[k-1];
            stg_b[k]   = b_q[k-1];
            stg_lo[k]  = res_view[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            sub_pipe <= '0;
            sat_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            lo_q     <= '0;
        end else if (adv) begin
            vld_pipe <= stg_vld;
            sub_pipe <= stg_sub;
            sat_pipe <= stg_sat;
            a_q      <= stg_a;
            b_q      <= stg_b;
            lo_q     <= stg_lo;
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic cin;
        if (k == 0) begin : g_cin0
            // A - B = A + ~B + 1
            assign cin = sub_i;
        end else begin : g_cinn
            assign cin = carry[k-1];
        end
        add_sub_seg #(.SEG_W(SEG_W)) u_seg (
            .clk   (clk_i),
            .rst   (rst_i),
            .en    (adv),
            .a     (stg_a[k][k*SEG_W +: SEG_W]),
            .b_eff (stg_b[k][k*SEG_W +: SEG_W]),
            .cin   (cin),
            .sum   (seg_sum[k]),
            .cout  (carry[k])
        );
    end

    // Output decode from the last stage's registers only, so everything
    // holds while stalled and reads as zero after reset.
    logic [WIDTH-1:0] sum;
    logic             a_msb, ovf_raw, sat_hit;
    add_sub_flags_t   flags;

    assign sum      = res_view[LAST];
    assign a_msb    = a_q[LAST][WIDTH-1];
    assign ovf_raw  = (a_msb == b_q[LAST][WIDTH-1]) && (sum[WIDTH-1] != a_msb);
    assign sat_hit  = sat_pipe[LAST] && ovf_raw;
    assign result_o = sat_hit ? WIDTH'(sat_value(a_msb, WIDTH)) : sum;

    always_comb begin
        flags = '0;
        if (vld_pipe[LAST]) begin
            // Borrow is the inverted carry of A + ~B + 1.
            flags.cout = (op_e'(sub_pipe[LAST]) == OP_SUB) ? ~carry[LAST] : carry[LAST];
            flags.ovf  = ovf_raw;
            flags.zero = (result_o == '0);
            flags.neg  = result_o[WIDTH-1];
        end
    end

    assign out_valid_o = vld_pipe[LAST];
    assign cout_o      = flags.cout;
    assign ovf_o       = flags.ovf;
    assign zero_o      = flags.zero;
    assign neg_o       = flags.neg;

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: directed self-checking bench for add_sub_pipe
// (WIDTH=32, SEG_W=8). Saturation vectors are active when
// ADD_SUB_PIPE_SAT_EN is defined.
module tb_add_sub_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         cout, ovf, zero, neg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(32), .SEG_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .sub_i       (sub),
`ifdef ADD_SUB_PIPE_SAT_EN
        .sat_i       (sat),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .cout_o      (cout),
        .ovf_o       (ovf),
        .zero_o      (zero),
        .neg_o       (neg)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single beat with out_ready held high; checks latency and all outputs.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tsub, input logic tsat, input logic [W-1:0] er,
                         input logic ec, input logic eo);
        int lat;
        out_ready = 1'b1;
        a = ta; b = tb_; sub = tsub; sat = tsat; in_valid = 1'b1;
        #1;
        chk({tag, " in_ready"}, W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, W'(lat), W'(4));
        chk({tag, " result"}, result, er);
        chk({tag, " cout"}, W'(cout), W'(ec));
        chk({tag, " ovf"}, W'(ovf), W'(eo));
        chk({tag, " zero"}, W'(zero), W'(er == '0));
        chk({tag, " neg"}, W'(neg), W'(er[W-1]));
        step();
        chk({tag, " drained"}, W'(out_valid), W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bp_exp [6];
        int tx, rx, stall_left, seen;
        logic acc;
        bp_exp = '{32'h0100_0000, 32'h0100_0001, 32'h0100_0002,
                   32'h0100_0003, 32'h0100_0004, 32'h0100_0005};

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst out_valid", W'(out_valid), W'(0));
        chk("rst result", result, 32'h0);
        chk("rst flags", W'({cout, ovf, zero, neg}), W'(0));
        chk("rst in_ready", W'(in_ready), W'(1));
        rst = 1'b0;
        step();

        // Basic add/sub and carry/borrow
        do_op("add ffffffff+1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op("add ff+1", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        do_op("sub 5-7", 32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        do_op("sub 7-5", 32'h7, 32'h5, 1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

        // Signed overflow, wrapping
        do_op("ovf add wrap", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op("ovf sub wrap", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
`ifdef ADD_SUB_PIPE_SAT_EN
        do_op("ovf add sat", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        do_op("ovf sub sat", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        do_op("sat no ovf", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
`endif

        // Back-pressure: 6 streamed beats, 3-cycle stall on first output
        tx = 0; rx = 0; stall_left = 3;
        for (int cyc = 0; cyc < 60 && rx < 6; cyc++) begin
            out_ready = !(out_valid && stall_left > 0);
            in_valid  = (tx < 6);
            a   = 32'h00FF_FFF0 + W'(tx);
            b   = 32'h10;
            sub = 1'b0;
            sat = 1'b0;
            #1;
            if (!out_ready) begin
                chk("bp stall in_ready", W'(in_ready), W'(0));
                chk("bp stall result", result, bp_exp[rx]);
                stall_left--;
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("bp result", result, bp_exp[rx]);
                rx++;
            end
            step();
            if (acc) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp beats out", W'(rx), W'(6));
        chk("bp beats in", W'(tx), W'(6));
        chk("bp stall cycles", W'(stall_left), W'(0));
        seen = 0;
        repeat (6) begin
            if (out_valid) seen++;
            step();
        end
        chk("bp no duplicate", W'(seen), W'(0));

        // Reset with 3 beats in flight; a beat offered during reset is dropped
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a = 32'h1000 + W'(k);
            b = 32'h1;
            sub = 1'b0;
            step();
        end
        chk("inflight not out yet", W'(out_valid), W'(0));
        rst = 1'b1;
        a = 32'h2000;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst2 out_valid", W'(out_valid), W'(0));
        chk("rst2 result", result, 32'h0);
        do_op("post rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        seen = 0;
        repeat (8) begin
            if (out_valid) seen++;
            step();
        end
        chk("rst dropped beats", W'(seen), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
